// File: rtl/serial_adder_if.sv
// Handshake/operand/result bundle for serial_adder.
// The i_sub field exists only when SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             i_start;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             i_cin;
`ifdef SERIAL_ADDER_SUB_EN
  logic             i_sub;
`endif
  logic             o_busy;
  logic             o_done;
  logic [WIDTH-1:0] o_sum;
  logic             o_cout;

  modport master (
`ifdef SERIAL_ADDER_SUB_EN
    output i_sub,
`endif
    output i_start, i_a, i_b, i_cin,
    input  o_busy, o_done, o_sum, o_cout
  );

  modport slave (
`ifdef SERIAL_ADDER_SUB_EN
    input  i_sub,
`endif
    input  i_start, i_a, i_b, i_cin,
    output o_busy, o_done, o_sum, o_cout
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell, LSB first, carry kept in a flop.
// Optional subtract mode is enabled with the SERIAL_ADDER_SUB_EN macro.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic            i_clk,
  input  logic            i_rst,
  serial_adder_if.slave   bus
);

  localparam int              CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic             r_c;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  logic             w_s;
  logic             w_co;
  logic [WIDTH-1:0] w_b_load;
  logic             w_c_load;

  function automatic logic fa_sum(input logic x, input logic y, input logic c);
    return x ^ y ^ c;
  endfunction

  function automatic logic fa_carry(input logic x, input logic y, input logic c);
    return (x & y) | (x & c) | (y & c);
  endfunction

  assign w_s  = fa_sum(r_sa[0], r_sb[0], r_c);
  assign w_co = fa_carry(r_sa[0], r_sb[0], r_c);

`ifdef SERIAL_ADDER_SUB_EN
  // a - b is a + ~b + 1; cin is ignored when subtracting
  assign w_b_load = bus.i_sub ? ~bus.i_b : bus.i_b;
  assign w_c_load = bus.i_sub ? 1'b1 : bus.i_cin;
`else
  assign w_b_load = bus.i_b;
  assign w_c_load = bus.i_cin;
`endif

  assign bus.o_busy = r_busy;
  assign bus.o_done = r_done;
  assign bus.o_sum  = r_sum;
  assign bus.o_cout = r_cout;

  // Sum bits enter r_sa from the top as operand A drains out of bit 0.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_sa    <= {WIDTH{1'b0}};
      r_sb    <= {WIDTH{1'b0}};
      r_c     <= 1'b0;
      r_cnt   <= {CW{1'b0}};
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sum   <= {WIDTH{1'b0}};
      r_cout  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (bus.i_start) begin
            r_sa    <= bus.i_a;
            r_sb    <= w_b_load;
            r_c     <= w_c_load;
            r_cnt   <= {CW{1'b0}};
            r_busy  <= 1'b1;
            r_state <= ST_RUN;
          end else begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          r_c  <= w_co;
          r_sa <= {w_s, r_sa[WIDTH-1:1]};
          r_sb <= {1'b0, r_sb[WIDTH-1:1]};
          if (r_cnt == CNT_LAST) begin
            r_cnt   <= {CW{1'b0}};
            r_sum   <= {w_s, r_sa[WIDTH-1:1]};
            r_cout  <= w_co;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_DONE;
          end else begin
            r_cnt   <= r_cnt + CNT_ONE;
            r_state <= ST_RUN;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): vector table, scoreboard queue,
// and hand-written sequences for ignored start, mid-run reset and back-to-back adds.
module tb_serial_adder;
  localparam int WIDTH = 8;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic [7:0] sum;
    logic       cout;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  logic [WIDTH:0]   exp_q[$];
  logic [WIDTH:0]   exp_v;
  logic [WIDTH-1:0] last_sum = '0;
  logic             last_cout = 1'b0;

  serial_adder_if #(.WIDTH(WIDTH)) bus();

  serial_adder #(.WIDTH(WIDTH)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: every done pulse pops one expected {cout,sum}.
  always @(negedge clk) begin
    if (!rst && bus.o_done === 1'b1) begin
      done_cnt = done_cnt + 1;
      if (exp_q.size() == 0) begin
        checks = checks + 1;
        errors = errors + 1;
        $display("FAIL spurious_done: got done=1 expected no pending result (cycle %0d)", cyc);
      end else begin
        exp_v = exp_q.pop_front();
        check("result_sum", 32'(bus.o_sum), 32'(exp_v[WIDTH-1:0]));
        check("result_cout", 32'(bus.o_cout), 32'(exp_v[WIDTH]));
        last_sum  = exp_v[WIDTH-1:0];
        last_cout = exp_v[WIDTH];
      end
    end
  end

  task automatic set_inputs(input vec_t v);
    bus.i_a   = v.a;
    bus.i_b   = v.b;
    bus.i_cin = v.cin;
`ifdef SERIAL_ADDER_SUB_EN
    bus.i_sub = v.sub;
`endif
  endtask

  // One add; inject>=0 pulses a bogus start (a=b=11) that many cycles into RUN.
  task automatic run_add(input vec_t v, input int inject);
    int   acc;
    int   at;
    int   busy_n;
    logic found;
    logic stable;
    vec_t bogus;
    bogus = '{8'h11, 8'h11, 1'b0, 1'b0, 8'h22, 1'b0};
    at = -1;
    busy_n = 0;
    found = 1'b0;
    stable = 1'b1;
    @(negedge clk);
    set_inputs(v);
    bus.i_start = 1'b1;
    exp_q.push_back({v.cout, v.sum});
    @(posedge clk);
    #1;
    acc = cyc;
    bus.i_start = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (k == inject) begin
        set_inputs(bogus);
        bus.i_start = 1'b1;
      end else begin
        bus.i_start = 1'b0;
      end
      if (bus.o_done === 1'b1) begin
        found = 1'b1;
        at = cyc;
      end else begin
        if (bus.o_busy === 1'b1) busy_n++;
        if (bus.o_sum !== last_sum || bus.o_cout !== last_cout) stable = 1'b0;
      end
    end
    bus.i_start = 1'b0;
    check("done_seen", 32'(found), 32'd1);
    check("latency", 32'(at - acc), 32'(WIDTH));
    check("busy_cycles", 32'(busy_n), 32'(WIDTH));
    check("result_hold_in_run", 32'(stable), 32'd1);
    @(negedge clk);
    check("done_one_cycle", 32'(bus.o_done), 32'd0);
    check("busy_after_done", 32'(bus.o_busy), 32'd0);
  endtask

  initial begin
    vec_t tbl[7];
    vec_t v;
    logic [8:0] r;
    int d0;
    int t1;
    int t2;
    logic f1;
    logic f2;

    tbl[0] = '{8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0};
    tbl[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1};
    tbl[2] = '{8'hA5, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b1};
    tbl[3] = '{8'h3C, 8'h42, 1'b0, 1'b0, 8'h7E, 1'b0};
    tbl[4] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1};
    tbl[5] = '{8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0};
    tbl[6] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1};

    bus.i_start = 1'b0;
    bus.i_a = '0;
    bus.i_b = '0;
    bus.i_cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    bus.i_sub = 1'b0;
`endif

    repeat (3) @(negedge clk);
    check("rst_busy", 32'(bus.o_busy), 32'd0);
    check("rst_done", 32'(bus.o_done), 32'd0);
    check("rst_sum", 32'(bus.o_sum), 32'd0);
    check("rst_cout", 32'(bus.o_cout), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 7; i++) run_add(tbl[i], -1);

    for (int i = 0; i < 4; i++) begin
      v.a = 8'($urandom);
      v.b = 8'($urandom);
      v.cin = 1'($urandom_range(0, 1));
      v.sub = 1'b0;
      r = {1'b0, v.a} + {1'b0, v.b} + {8'h00, v.cin};
      v.sum = r[7:0];
      v.cout = r[8];
      run_add(v, -1);
    end

`ifdef SERIAL_ADDER_SUB_EN
    v = '{8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1};
    run_add(v, -1);
    v = '{8'h01, 8'h02, 1'b0, 1'b1, 8'hFF, 1'b0};
    run_add(v, -1);
    v = '{8'h05, 8'h05, 1'b0, 1'b1, 8'h00, 1'b1};
    run_add(v, -1);
    v = '{8'h05, 8'h03, 1'b1, 1'b0, 8'h09, 1'b0};
    run_add(v, -1);
`endif

    // start while busy is ignored
    d0 = done_cnt;
    run_add(tbl[3], 3);
    repeat (12) @(negedge clk);
    check("single_done_pulse", 32'(done_cnt - d0), 32'd1);

    // reset in the middle of RUN discards the add
    @(negedge clk);
    set_inputs(tbl[1]);
    bus.i_start = 1'b1;
    @(posedge clk);
    #1;
    bus.i_start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", 32'(bus.o_busy), 32'd0);
    check("midrst_done", 32'(bus.o_done), 32'd0);
    check("midrst_sum", 32'(bus.o_sum), 32'd0);
    check("midrst_cout", 32'(bus.o_cout), 32'd0);
    rst = 1'b0;
    last_sum = '0;
    last_cout = 1'b0;
    d0 = done_cnt;
    repeat (15) @(negedge clk);
    check("no_done_after_rst", 32'(done_cnt - d0), 32'd0);

    // start held through DONE: back-to-back adds
    @(negedge clk);
    set_inputs(tbl[3]);
    bus.i_start = 1'b1;
    exp_q.push_back({1'b0, 8'h7E});
    @(posedge clk);
    #1;
    v = '{8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0};
    set_inputs(v);
    exp_q.push_back({1'b0, 8'h03});
    f1 = 1'b0;
    t1 = -1;
    for (int k = 0; k < 20 && !f1; k++) begin
      @(negedge clk);
      if (bus.o_done === 1'b1) begin
        f1 = 1'b1;
        t1 = cyc;
      end
    end
    @(posedge clk);
    #1;
    bus.i_start = 1'b0;
    f2 = 1'b0;
    t2 = -100;
    for (int k = 0; k < 20 && !f2; k++) begin
      @(negedge clk);
      if (bus.o_done === 1'b1) begin
        f2 = 1'b1;
        t2 = cyc;
      end
    end
    check("b2b_first_done", 32'(f1), 32'd1);
    check("b2b_second_done", 32'(f2), 32'd1);
    check("b2b_spacing", 32'(t2 - t1), 32'(WIDTH + 1));
    repeat (12) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
